// File: rtl/cpu_ctrl_sequencer_pkg.sv
// ============================================================================
// Package: cpu_ctrl_sequencer_pkg
// Purpose: Shared definitions for the CPU control sequencer.
//          Provides the opcode map, the sequencer state encoding, the
//          register-file write-source codes and small opcode classifiers.
// Ports:   none (package)
// ============================================================================
package cpu_ctrl_sequencer_pkg;

    // Opcode map, taken from instr[23:20]
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_BEZ = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Register-file write source select
    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_IMM = 2'd1;
    localparam logic [1:0] WSEL_MEM = 2'd2;

    // Sequencer states; S_STEP_WAIT is only reachable in single-step builds
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_STEP_WAIT
    } seq_state_e;

    // ALU operations and LDI are the opcodes that write back from EXEC
    function automatic logic writesFromExec(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LDI);
    endfunction

    // Write source for EXEC-originated writebacks (LD selects WSEL_MEM itself)
    function automatic logic [1:0] execWsel(input logic [3:0] op);
        return (op == OP_LDI) ? WSEL_IMM : WSEL_ALU;
    endfunction

    // Opcodes B..E are undefined and run as NOP
    function automatic logic isIllegal(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// ============================================================================
// Interface: cpu_ctrl_sequencer_if
// Purpose:   Bundles the sequencer's connection to the instruction ROM and
//            the datapath (register file, ALU, data memory).
// Signals:   instr    - 24-bit instruction word at iaddr (combinational ROM)
//            alu_zero - ALU zero flag of Ra
//            mem_ack  - data memory / peripheral done
//            iaddr    - program counter
//            ir_load  - latch instr into datapath IR
//            alu_op   - registered opcode to the ALU
//            rf_we    - register-file write strobe
//            rf_wsel  - write source: 0 ALU, 1 immediate, 2 data_in
//            mem_req  - data access request
//            data_wr  - 1 = store, valid with mem_req
//            illegal  - pulse on undefined opcode
//            bus_err  - pulse on memory timeout abort
//            halted   - high in HALT
// Modports:  master = sequencer side, slave = datapath/ROM side
// ============================================================================
interface cpu_ctrl_sequencer_if #(
    parameter int PC_W = 4
);
    logic [23:0]     instr;
    logic            alu_zero;
    logic            mem_ack;
    logic [PC_W-1:0] iaddr;
    logic            ir_load;
    logic [3:0]      alu_op;
    logic            rf_we;
    logic [1:0]      rf_wsel;
    logic            mem_req;
    logic            data_wr;
    logic            illegal;
    logic            bus_err;
    logic            halted;

    modport master (
        input  instr, alu_zero, mem_ack,
        output iaddr, ir_load, alu_op, rf_we, rf_wsel,
               mem_req, data_wr, illegal, bus_err, halted
    );

    modport slave (
        output instr, alu_zero, mem_ack,
        input  iaddr, ir_load, alu_op, rf_we, rf_wsel,
               mem_req, data_wr, illegal, bus_err, halted
    );
endinterface

// File: rtl/cpu_ctrl_sequencer_pc_unit.sv
// ============================================================================
// Module: cpu_pc_unit
// Purpose: Program counter register for the control sequencer.
//          Loads a branch target or increments modulo 2^PC_W.
// Ports:   clk      - system clock
//          rst_n    - asynchronous active-low reset (PC <= RESET_PC)
//          i_inc    - advance PC by one (wraps)
//          i_load   - load i_target (wins over i_inc)
//          i_target - branch / jump target
//          o_pc     - current program counter
// ============================================================================
module cpu_pc_unit #(
    parameter int PC_W     = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_inc,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // PC register: a taken branch replaces the PC, otherwise the sequencer
    // may step it forward; the add simply wraps at 2^PC_W with no flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= PC_W'(RESET_PC);
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// ============================================================================
// Module: cpu_ctrl_sequencer
// Purpose: Multi-cycle control FSM for the 16-bit CPU core. Fetches from the
//          instruction ROM, decodes instr[23:20] and sequences register-file
//          writes, ALU op select and data-memory request/acknowledge. Holds
//          no data registers; the datapath sits beside it.
// Ports:   clk        - system clock
//          rst_n      - asynchronous active-low reset
//          i_step_en  - single-step enable   (CPU_SEQ_STEP_EN builds only)
//          i_step_req - single-step advance  (CPU_SEQ_STEP_EN builds only)
//          io_bus     - cpu_ctrl_sequencer_if.master (ROM + datapath signals)
// Config:  `define CPU_SEQ_STEP_EN adds the single-step ports and the
//          STEP_WAIT state; without it execution is free-running.
// ============================================================================
module cpu_ctrl_sequencer
    import cpu_ctrl_sequencer_pkg::*;
#(
    parameter int PC_W        = 4,
    parameter int RESET_PC    = 0,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef CPU_SEQ_STEP_EN
    input  logic                 i_step_en,
    input  logic                 i_step_req,
`endif
    cpu_ctrl_sequencer_if.master io_bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    seq_state_e      r_state;
    logic [3:0]      r_aluOp;
    logic [PC_W-1:0] r_target;
    logic            r_rfWe;
    logic [1:0]      r_rfWsel;
    logic            r_memReq;
    logic            r_dataWr;
    logic            r_illegal;
    logic            r_busErr;
    logic            r_halted;
    logic [CNT_W-1:0] r_memCnt;

    logic            w_pcInc;
    logic            w_pcLoad;
    logic            w_memTimeout;
    logic [PC_W-1:0] w_pc;
    seq_state_e      w_doneState;
    logic            w_unused;

    // Only opcode and target field of the instruction matter here
    assign w_unused = &{1'b0, io_bus.instr};

    // A zero MEM_TIMEOUT means wait forever, so the abort never fires
    assign w_memTimeout = (MEM_TIMEOUT > 0) && (r_memCnt == CNT_LAST);

    // Where an instruction goes once it has finished
`ifdef CPU_SEQ_STEP_EN
    assign w_doneState = i_step_en ? S_STEP_WAIT : S_FETCH;
`else
    assign w_doneState = S_FETCH;
`endif

    // PC control: taken JMP/BEZ load the target; NOP-like EXEC, ST ack,
    // any MEM abort and WB step forward. ALU/LDI defer the step to WB.
    always_comb begin
        w_pcInc  = 1'b0;
        w_pcLoad = 1'b0;
        case (r_state)
            S_EXEC: begin
                if (r_aluOp == OP_JMP || (r_aluOp == OP_BEZ && io_bus.alu_zero)) begin
                    w_pcLoad = 1'b1;
                end else if (!writesFromExec(r_aluOp)) begin
                    w_pcInc = 1'b1;
                end
            end
            S_MEM: begin
                if (io_bus.mem_ack) begin
                    w_pcInc = (r_aluOp == OP_ST);
                end else begin
                    w_pcInc = w_memTimeout;
                end
            end
            S_WB:    w_pcInc = 1'b1;
            default: w_pcInc = 1'b0;
        endcase
    end

    cpu_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_pcInc),
        .i_load   (w_pcLoad),
        .i_target (r_target),
        .o_pc     (w_pc)
    );

    // Main sequencer. Outputs are registered alongside the state they belong
    // to, so each strobe is high exactly for the cycles spent in its state.
    // An ack on the same cycle as the last allowed MEM cycle wins over abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_aluOp   <= OP_NOP;
            r_target  <= '0;
            r_rfWe    <= 1'b0;
            r_rfWsel  <= WSEL_ALU;
            r_memReq  <= 1'b0;
            r_dataWr  <= 1'b0;
            r_illegal <= 1'b0;
            r_busErr  <= 1'b0;
            r_halted  <= 1'b0;
            r_memCnt  <= '0;
        end else begin
            r_rfWe    <= 1'b0;
            r_illegal <= 1'b0;
            r_busErr  <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_aluOp   <= io_bus.instr[23:20];
                    r_target  <= io_bus.instr[PC_W-1:0];
                    r_illegal <= isIllegal(io_bus.instr[23:20]);
                    r_state   <= S_DECODE;
                end
                S_DECODE: begin
                    if (r_aluOp == OP_LD || r_aluOp == OP_ST) begin
                        r_memReq <= 1'b1;
                        r_dataWr <= (r_aluOp == OP_ST);
                        r_memCnt <= '0;
                        r_state  <= S_MEM;
                    end else if (r_aluOp == OP_HLT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (writesFromExec(r_aluOp)) begin
                        r_rfWe   <= 1'b1;
                        r_rfWsel <= execWsel(r_aluOp);
                        r_state  <= S_WB;
                    end else begin
                        r_state  <= w_doneState;
                    end
                end
                S_MEM: begin
                    if (io_bus.mem_ack) begin
                        r_memReq <= 1'b0;
                        r_dataWr <= 1'b0;
                        if (r_aluOp == OP_LD) begin
                            r_rfWe   <= 1'b1;
                            r_rfWsel <= WSEL_MEM;
                            r_state  <= S_WB;
                        end else begin
                            r_state  <= w_doneState;
                        end
                    end else if (w_memTimeout) begin
                        r_memReq <= 1'b0;
                        r_dataWr <= 1'b0;
                        r_busErr <= 1'b1;
                        r_state  <= w_doneState;
                    end else begin
                        r_memCnt <= r_memCnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    r_rfWsel <= WSEL_ALU;
                    r_state  <= w_doneState;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
`ifdef CPU_SEQ_STEP_EN
                S_STEP_WAIT: begin
                    if (i_step_req) begin
                        r_state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // ir_load is the FETCH state itself; gating with rst_n keeps every
    // output low while reset is held.
    assign io_bus.ir_load = rst_n && (r_state == S_FETCH);
    assign io_bus.iaddr   = w_pc;
    assign io_bus.alu_op  = r_aluOp;
    assign io_bus.rf_we   = r_rfWe;
    assign io_bus.rf_wsel = r_rfWsel;
    assign io_bus.mem_req = r_memReq;
    assign io_bus.data_wr = r_dataWr;
    assign io_bus.illegal = r_illegal;
    assign io_bus.bus_err = r_busErr;
    assign io_bus.halted  = r_halted;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// ============================================================================
// Testbench: tb_cpu_ctrl_sequencer
// Purpose:   Drives cpu_ctrl_sequencer through directed and random
//            instruction streams and compares every cycle against an
//            instruction-level timing model (latency table per opcode class).
// ============================================================================
module tb_cpu_ctrl_sequencer;

    localparam int MEM_TIMEOUT = 16;

    logic clk;
    logic rst_n;

    cpu_ctrl_sequencer_if #(.PC_W(4)) bus ();

    cpu_ctrl_sequencer #(
        .PC_W        (4),
        .RESET_PC    (0),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.master)
    );

    // Instruction ROM contents; the bench writes each word just before use
    logic [23:0] rom [16];
    assign bus.instr = rom[bus.iaddr];

    int          nChecks;
    int          nPass;
    int          curCyc;
    logic [3:0]  expPc;
    logic        expBusErrNext;

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still terminates with a visible report
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and counts a pass or reports the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s pc=%0d cyc=%0d observed=%0h expected=%0h",
                    tag, expPc, curCyc, observed, expected);
    endtask

    // Runs one instruction at the model's PC. The model derives from the
    // opcode class how many cycles it takes, on which cycle the register
    // write happens, which cycles request memory and where the PC goes.
    // ackDelay = n acks on the n-th memory cycle; 0 means never ack.
    task automatic applyStimulus(input logic [23:0] word, input int ackDelay,
                                 input logic zero);
        logic [3:0] op;
        logic [3:0] nextPc;
        logic [1:0] wsel;
        logic       timedOut;
        logic       isIll;
        logic       isSt;
        int         len;
        int         weCyc;
        int         memFirst;
        int         memLast;
        int         n;
        op       = word[23:20];
        nextPc   = expPc + 4'd1;
        wsel     = 2'd0;
        timedOut = 1'b0;
        isIll    = 1'b0;
        isSt     = (op == 4'h8);
        weCyc    = -1;
        memFirst = -1;
        memLast  = -2;
        if (op >= 4'h1 && op <= 4'h6) begin
            len   = 4;
            weCyc = 3;
            wsel  = (op == 4'h6) ? 2'd1 : 2'd0;
        end else if (op == 4'h7 || op == 4'h8) begin
            timedOut = (ackDelay < 1) || (ackDelay > MEM_TIMEOUT);
            n        = timedOut ? MEM_TIMEOUT : ackDelay;
            memFirst = 2;
            memLast  = 1 + n;
            if (op == 4'h7 && !timedOut) begin
                len   = 3 + n;
                weCyc = 2 + n;
                wsel  = 2'd2;
            end else begin
                len = 2 + n;
            end
        end else begin
            len   = 3;
            isIll = (op >= 4'hB) && (op <= 4'hE);
            if (op == 4'h9 || (op == 4'hA && zero)) nextPc = word[3:0];
        end
        rom[expPc] = word;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            curCyc       = k;
            bus.alu_zero = zero;
            if (k >= memFirst && k <= memLast)
                bus.mem_ack = (k == memLast) && !timedOut;
            else
                bus.mem_ack = 1'($urandom_range(0, 1));
            checkOutput("iaddr", 32'(bus.iaddr), 32'(expPc));
            checkOutput("ir_load", 32'(bus.ir_load), 32'(k == 0));
            checkOutput("rf_we", 32'(bus.rf_we), 32'(k == weCyc));
            if (k == weCyc) checkOutput("rf_wsel", 32'(bus.rf_wsel), 32'(wsel));
            checkOutput("mem_req", 32'(bus.mem_req), 32'(k >= memFirst && k <= memLast));
            if (k >= memFirst && k <= memLast)
                checkOutput("data_wr", 32'(bus.data_wr), 32'(isSt));
            checkOutput("illegal", 32'(bus.illegal), 32'(k == 1 && isIll));
            checkOutput("bus_err", 32'(bus.bus_err), 32'(k == 0 && expBusErrNext));
            checkOutput("halted", 32'(bus.halted), 32'(0));
            if (k == 1) checkOutput("alu_op", 32'(bus.alu_op), 32'(op));
        end
        expPc         = nextPc;
        expBusErrNext = timedOut;
    endtask

    // Directed scenario followed by a random instruction stream
    initial begin
        logic [3:0] rop;
        int         r;
        nChecks       = 0;
        nPass         = 0;
        curCyc        = 0;
        expPc         = 4'd0;
        expBusErrNext = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 24'h0;
        rst_n        = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.alu_zero = 1'b0;

        // Reset state while reset is held
        #3;
        checkOutput("rst_iaddr", 32'(bus.iaddr), 32'(0));
        checkOutput("rst_ir_load", 32'(bus.ir_load), 32'(0));
        checkOutput("rst_rf_we", 32'(bus.rf_we), 32'(0));
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'(0));
        checkOutput("rst_halted", 32'(bus.halted), 32'(0));
        checkOutput("rst_alu_op", 32'(bus.alu_op), 32'(0));
        checkOutput("rst_bus_err", 32'(bus.bus_err), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD at 0, LD acked on 3rd cycle, ST with no ack, ST acked at limit
        applyStimulus(24'h130102, 0, 1'b0);
        applyStimulus(24'h700005, 3, 1'b0);
        applyStimulus(24'h800007, 0, 1'b0);
        applyStimulus(24'h80000A, MEM_TIMEOUT, 1'b0);
        applyStimulus(24'h800003, 1, 1'b0);
        applyStimulus(24'h600055, 0, 1'b0);
        // JMP at 15 to 4, then NOP at 15 wrapping to 0
        applyStimulus(24'h90000F, 0, 1'b0);
        applyStimulus(24'h900004, 0, 1'b0);
        applyStimulus(24'h90000F, 0, 1'b0);
        applyStimulus(24'h000000, 0, 1'b0);
        // BEZ not taken then taken, then an undefined opcode
        applyStimulus(24'hA00009, 0, 1'b0);
        applyStimulus(24'hA00009, 0, 1'b1);
        applyStimulus(24'hC00000, 0, 1'b0);
        applyStimulus(24'h710003, 20, 1'b0);

        // Random stream of every opcode except HLT
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 14));
            r   = $urandom_range(0, 9);
            applyStimulus({rop, 20'($urandom)},
                          (r == 0) ? 0 : (r == 1) ? MEM_TIMEOUT : $urandom_range(1, 4),
                          1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a load: request drops without a clock
        rom[expPc] = 24'h730000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        checkOutput("mem_req_pre_reset", 32'(bus.mem_req), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_mem_req", 32'(bus.mem_req), 32'(0));
        checkOutput("midrst_iaddr", 32'(bus.iaddr), 32'(0));
        checkOutput("midrst_rf_we", 32'(bus.rf_we), 32'(0));
        checkOutput("midrst_data_wr", 32'(bus.data_wr), 32'(0));
        checkOutput("midrst_ir_load", 32'(bus.ir_load), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        expPc         = 4'd0;
        expBusErrNext = 1'b0;
        applyStimulus(24'h200000, 0, 1'b0);
        applyStimulus(24'h000000, 0, 1'b0);

        // HLT: halted held, PC frozen, no strobes for 100 cycles
        rom[expPc] = 24'hF00000;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checkOutput("hlt_ir_load", 32'(bus.ir_load), 32'(1));
        @(negedge clk);
        checkOutput("hlt_decode_halted", 32'(bus.halted), 32'(0));
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            curCyc      = k + 2;
            bus.mem_ack = 1'($urandom_range(0, 1));
            checkOutput("hlt_halted", 32'(bus.halted), 32'(1));
            checkOutput("hlt_iaddr", 32'(bus.iaddr), 32'(expPc));
            checkOutput("hlt_ir_load", 32'(bus.ir_load), 32'(0));
            checkOutput("hlt_rf_we", 32'(bus.rf_we), 32'(0));
            checkOutput("hlt_mem_req", 32'(bus.mem_req), 32'(0));
        end

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
